// File: rtl/sc_load_controller_if.sv
// Host / transmitter / readback signal bundle for the slow-control load controller.
// master = host + transmitter side, slave = controller.
interface sc_load_controller_if #(
    parameter int FRAME_LEN = 829,
    parameter int MAX_RETRY = 3
);
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic                 host_req;
    logic [FRAME_LEN-1:0] host_frame;
    logic                 host_ack;
    logic                 refresh_en;
    logic                 tx_start;
    logic [FRAME_LEN-1:0] tx_frame;
    logic                 q_sc;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [RW-1:0]        retry_cnt;

    modport master (
        output host_req, host_frame, refresh_en, q_sc,
        input  host_ack, tx_start, tx_frame, busy, done, err, retry_cnt
    );

    modport slave (
        input  host_req, host_frame, refresh_en, q_sc,
        output host_ack, tx_start, tx_frame, busy, done, err, retry_cnt
    );
endinterface

// File: rtl/sc_load_controller.sv
// Sequences MAROC slow-control loads (host or periodic refresh) with optional readback verify and bounded retry.
// Latency: host_ack (comb, IDLE) -> done 2*(TX_LATENCY+FRAME_LEN)+4 cycles with verify, no retry.
// Backpressure: host_req is held off while busy and acknowledged on the first IDLE cycle.
module sc_load_controller #(
    parameter int FRAME_LEN      = 829,
    parameter int TX_LATENCY     = 1,
    parameter bit VERIFY         = 1'b1,
    parameter int MAX_RETRY      = 3,
    parameter int REFRESH_PERIOD = 5000000
) (
    input  logic            clk,
    input  logic            rstn,
    sc_load_controller_if.slave sc
);
    localparam int WIN  = TX_LATENCY + FRAME_LEN;
    localparam int BW   = $clog2(WIN + 1);
    localparam int REFW = $clog2(REFRESH_PERIOD + 1);
    localparam int RW   = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD, S_VSTART, S_VERIFY, S_CHECK
    } state_t;

    state_t               r_state, w_next;
    logic [BW-1:0]        r_bit_cnt;
    logic [REFW-1:0]      r_ref_cnt;
    logic [RW-1:0]        r_retry;
    logic [FRAME_LEN-1:0] r_shadow;
    logic [FRAME_LEN-1:0] r_readback;
    logic                 r_cfg_valid;
    logic                 r_done;
    logic                 r_err;

    logic w_host_go, w_ref_go, w_win_end, w_match, w_can_retry;

    assign w_host_go   = (r_state == S_IDLE) && sc.host_req;
    assign w_ref_go    = (r_state == S_IDLE) && !sc.host_req && sc.refresh_en && r_cfg_valid
                         && (r_ref_cnt == REFW'(REFRESH_PERIOD - 1));
    assign w_win_end   = (r_bit_cnt == BW'(WIN - 1));
    assign w_match     = (r_readback == r_shadow);
    assign w_can_retry = (r_retry < RW'(MAX_RETRY));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_host_go || w_ref_go) w_next = S_START;
            S_START:  w_next = S_LOAD;
            S_LOAD:   if (w_win_end) w_next = VERIFY ? S_VSTART : S_IDLE;
            S_VSTART: w_next = S_VERIFY;
            S_VERIFY: if (w_win_end) w_next = S_CHECK;
            S_CHECK:  w_next = (!w_match && w_can_retry) ? S_START : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_ref_cnt   <= '0;
            r_retry     <= '0;
            r_shadow    <= '0;
            r_readback  <= '0;
            r_cfg_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;

            // Counts idle cycles only; any exit from IDLE restarts the refresh interval.
            if (r_state != S_IDLE || !sc.refresh_en || w_host_go || w_ref_go)
                r_ref_cnt <= '0;
            else
                r_ref_cnt <= r_ref_cnt + REFW'(1);

            if (w_host_go) begin
                r_shadow <= sc.host_frame;
                r_err    <= 1'b0;
            end
            if (w_host_go || w_ref_go)
                r_retry <= '0;

            if (r_state == S_START || r_state == S_VSTART)
                r_bit_cnt <= '0;
            else if (r_state == S_LOAD || r_state == S_VERIFY)
                r_bit_cnt <= r_bit_cnt + BW'(1);

            // First frame bit arrives TX_LATENCY cycles into the window; capture LSB-first.
            if (r_state == S_VERIFY && r_bit_cnt >= BW'(TX_LATENCY))
                r_readback <= {sc.q_sc, r_readback[FRAME_LEN-1:1]};

            if (r_state == S_LOAD && w_win_end && !VERIFY) begin
                r_done      <= 1'b1;
                r_cfg_valid <= 1'b1;
            end

            if (r_state == S_CHECK) begin
                if (w_match) begin
                    r_done      <= 1'b1;
                    r_cfg_valid <= 1'b1;
                end else if (w_can_retry) begin
                    r_retry <= r_retry + RW'(1);
                end else begin
                    r_err       <= 1'b1;
                    r_done      <= 1'b1;
                    r_cfg_valid <= 1'b0;
                end
            end
        end
    end

    // Reset gating keeps host_ack low while rstn is asserted.
    assign sc.host_ack  = w_host_go && rstn;
    assign sc.tx_start  = (r_state == S_START) || (r_state == S_VSTART);
    assign sc.tx_frame  = r_shadow;
    assign sc.busy      = (r_state != S_IDLE);
    assign sc.done      = r_done;
    assign sc.err       = r_err;
    assign sc.retry_cnt = r_retry;
endmodule

// File: tb/tb_sc_load_controller.sv
// Directed bench for sc_load_controller with a MAROC loopback model and a done-time scoreboard.
module tb_sc_load_controller;
    localparam int FL  = 16;
    localparam int TXL = 1;
    localparam int MR  = 2;
    localparam int RP  = 100;

    typedef struct {
        logic [FL-1:0] frame;
        logic          err;
        logic [1:0]    retry;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sc_load_controller_if #(.FRAME_LEN(FL), .MAX_RETRY(MR)) a ();
    sc_load_controller_if #(.FRAME_LEN(FL), .MAX_RETRY(MR)) b ();

    sc_load_controller #(.FRAME_LEN(FL), .TX_LATENCY(TXL), .VERIFY(1'b1),
                         .MAX_RETRY(MR), .REFRESH_PERIOD(RP))
        dut (.clk(clk), .rstn(rstn), .sc(a.slave));

    sc_load_controller #(.FRAME_LEN(FL), .TX_LATENCY(TXL), .VERIFY(1'b0),
                         .MAX_RETRY(MR), .REFRESH_PERIOD(RP))
        dut_nv (.clk(clk), .rstn(rstn), .sc(b.slave));

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    // Monitor / loopback state, updated 1 ns before each rising edge.
    int cyc = 0;
    int n_txs = 0, last_txs = 0, prev_txs = 0;
    int n_done = 0, last_done = 0;
    int n_ack = 0, last_ack = 0;
    int b_ntxs = 0, b_txs = 0, b_ndone = 0, b_done = 0;
    int lb = 1000;
    logic [FL-1:0] sreg = '0, out_frame = '0, prev_frame = '0;
    logic [FL-1:0] done_frame = '0;
    logic          done_err = 1'b0;
    logic [1:0]    done_retry = '0;
    logic          was_busy = 1'b0, frame_moved = 1'b0, force0 = 1'b0;

    always begin
        @(negedge clk);
        #4;
        cyc++;
        if (a.tx_start) begin
            prev_txs = last_txs; last_txs = cyc; n_txs++;
            out_frame = sreg; sreg = a.tx_frame; lb = 0;
        end else begin
            lb++;
        end
        if (a.done) begin
            n_done++; last_done = cyc;
            done_frame = a.tx_frame; done_err = a.err; done_retry = a.retry_cnt;
        end
        if (a.host_ack) begin n_ack++; last_ack = cyc; end
        if (a.busy && was_busy && a.tx_frame !== prev_frame) frame_moved = 1'b1;
        was_busy = a.busy; prev_frame = a.tx_frame;
        a.q_sc = (!force0 && lb >= 1 + TXL && lb < 1 + TXL + FL) ? out_frame[lb-1-TXL] : 1'b0;
        if (b.tx_start) begin b_ntxs++; b_txs = cyc; end
        if (b.done) begin b_ndone++; b_done = cyc; end
        b.q_sc = 1'b0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [FL-1:0] f, input logic e, input logic [1:0] r);
        exp_t x;
        x.frame = f; x.err = e; x.retry = r;
        sb.push_back(x);
    endtask

    task automatic host_load(input logic [FL-1:0] f, output int ack_c);
        int n0;
        n0 = n_ack;
        a.host_frame = f;
        a.host_req   = 1'b1;
        for (int i = 0; i < 400 && n_ack == n0; i++) @(negedge clk);
        chk("ack_seen", n_ack - n0, 1);
        a.host_req = 1'b0;
        ack_c = last_ack;
    endtask

    task automatic wait_done(output int done_c);
        int n0;
        exp_t e;
        n0 = n_done;
        for (int i = 0; i < 500 && n_done == n0; i++) @(negedge clk);
        chk("done_seen", n_done - n0, 1);
        done_c = last_done;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_frame", done_frame, e.frame);
            chk("sb_err", done_err, e.err);
            chk("sb_retry", done_retry, e.retry);
        end else begin
            chk("sb_nonempty_at_done", sb.size(), 1);
        end
    endtask

    task automatic wait_until(input int c);
        for (int i = 0; i < 1000 && (cyc + 1) < c; i++) @(negedge clk);
    endtask

    initial begin
        int t, d, d2, n0, na, en_c;
        a.host_req = 1'b0; a.host_frame = '0; a.refresh_en = 1'b0;
        b.host_req = 1'b0; b.host_frame = '0; b.refresh_en = 1'b0;

        // Reset state, with host_req asserted to confirm host_ack is held low.
        repeat (3) @(negedge clk);
        a.host_req = 1'b1;
        #1;
        chk("rst_busy", a.busy, 0);
        chk("rst_tx_start", a.tx_start, 0);
        chk("rst_done", a.done, 0);
        chk("rst_err", a.err, 0);
        chk("rst_retry", a.retry_cnt, 0);
        chk("rst_tx_frame", a.tx_frame, 0);
        chk("rst_host_ack", a.host_ack, 0);
        a.host_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // No refresh before the first successful load.
        a.refresh_en = 1'b1;
        n0 = n_txs;
        repeat (150) @(negedge clk);
        chk("no_refresh_before_load", n_txs - n0, 0);
        a.refresh_en = 1'b0;

        // 1: good loopback load.
        frame_moved = 1'b0;
        n0 = n_txs;
        push_exp(16'hA5C3, 1'b0, 2'd0);
        host_load(16'hA5C3, t);
        wait_done(d);
        chk("t1_ack_to_done", d - t, 38);
        chk("t1_start_after_ack", prev_txs - t, 1);
        chk("t1_txstart_gap", last_txs - prev_txs, 18);
        chk("t1_txstart_count", n_txs - n0, 2);
        chk("t1_frame_stable", frame_moved, 0);

        // 2: readback stuck at 0 -> retries exhausted, err; next load clears err.
        force0 = 1'b1;
        n0 = n_txs;
        push_exp(16'hA5C3, 1'b1, 2'd2);
        host_load(16'hA5C3, t);
        wait_done(d);
        chk("t2_ack_to_done", d - t, 112);
        chk("t2_txstart_count", n_txs - n0, 6);
        chk("t2_err_sticky", a.err, 1);
        force0 = 1'b0;
        push_exp(16'hA5C3, 1'b0, 2'd0);
        host_load(16'hA5C3, t);
        chk("t2_err_cleared_on_ack", a.err, 0);
        wait_done(d);

        // 3: VERIFY=0 instance, single start pulse.
        n0 = b_ntxs; na = b_ndone;
        b.host_frame = 16'h0001;
        b.host_req = 1'b1;
        for (int i = 0; i < 50 && b_ntxs == n0; i++) @(negedge clk);
        b.host_req = 1'b0;
        for (int i = 0; i < 50 && b_ndone == na; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t3_done_count", b_ndone - na, 1);
        chk("t3_txstart_count", b_ntxs - n0, 1);
        chk("t3_start_to_done", b_done - b_txs, 18);
        chk("t3_err", b.err, 0);
        chk("t3_tx_frame", b.tx_frame, 16'h0001);

        // 4: periodic refresh after success.
        a.refresh_en = 1'b1;
        en_c = cyc + 1;
        push_exp(16'hA5C3, 1'b0, 2'd0);
        wait_done(d);
        chk("t4_first_refresh", prev_txs - en_c, 100);
        push_exp(16'hA5C3, 1'b0, 2'd0);
        wait_done(d2);
        chk("t4_refresh_period", prev_txs - d, 100);
        a.refresh_en = 1'b0;

        // 5: host_req raised mid-LOAD is held off until IDLE.
        frame_moved = 1'b0;
        push_exp(16'hA5C3, 1'b0, 2'd0);
        host_load(16'hA5C3, t);
        repeat (5) @(negedge clk);
        chk("t5_busy_mid_load", a.busy, 1);
        na = n_ack;
        push_exp(16'hFFFF, 1'b0, 2'd0);
        a.host_frame = 16'hFFFF;
        a.host_req = 1'b1;
        wait_done(d);
        chk("t5_ack_count", n_ack - na, 1);
        chk("t5_ack_at_idle", last_ack, d);
        chk("t5_frame_stable", frame_moved, 0);
        a.host_req = 1'b0;
        wait_done(d);

        // 5b: host_req on the refresh tick cycle wins.
        a.refresh_en = 1'b1;
        en_c = cyc + 1;
        wait_until(en_c + 99);
        na = n_ack;
        push_exp(16'h3C5A, 1'b0, 2'd0);
        a.host_frame = 16'h3C5A;
        a.host_req = 1'b1;
        @(negedge clk);
        a.host_req = 1'b0;
        chk("t5_tie_ack_count", n_ack - na, 1);
        chk("t5_tie_ack_cycle", last_ack, en_c + 99);
        chk("t5_tie_frame", a.tx_frame, 16'h3C5A);
        wait_done(d);
        a.refresh_en = 1'b0;

        // 6: reset mid-VERIFY abandons the operation and cfg_valid.
        host_load(16'h0F0F, t);
        wait_until(t + 25);
        chk("t6_busy_before_rst", a.busy, 1);
        na = n_done;
        rstn = 1'b0;
        #1;
        chk("t6_busy", a.busy, 0);
        chk("t6_tx_start", a.tx_start, 0);
        chk("t6_done", a.done, 0);
        chk("t6_err", a.err, 0);
        chk("t6_retry", a.retry_cnt, 0);
        chk("t6_tx_frame", a.tx_frame, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        a.refresh_en = 1'b1;
        n0 = n_txs;
        repeat (150) @(negedge clk);
        chk("t6_no_done", n_done - na, 0);
        chk("t6_no_refresh", n_txs - n0, 0);
        a.refresh_en = 1'b0;

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
